upsampler_feed_fifo: RTL

- Sample-feeding buffer directly upstream of the upsampler filter chain.
- Accepts 16-bit baseband samples from the SoC side (DMA/CSR streamer) on a valid/ready port.
- Presents one registered sample on filter_in each time the upsampler's ce_out (sample request) strobes.
- Handles priming, underflow policy and status counters so the interpolator always sees a defined input.

---
 rtl/upsampler_feed_fifo_if.sv | 8 +
 rtl/upsampler_feed_fifo.sv | 80 ++++++++
 2 files changed

// File: rtl/upsampler_feed_fifo_if.sv
// upsampler_feed_fifo_if: valid/ready sample stream from the SoC into the feed FIFO
interface upsampler_feed_fifo_if #(parameter int DW = 16);
  logic [DW-1:0] tdata;
  logic tvalid;
  logic tready;
  modport master (output tdata, output tvalid, input tready);
  modport slave (input tdata, input tvalid, output tready);
endinterface

// File: rtl/upsampler_feed_fifo.sv
// upsampler_feed_fifo: primed sample FIFO presenting one registered sample per upsampler request
module upsampler_feed_fifo #(
  parameter int DW = 16,
  parameter int DEPTH = 32,
  parameter int PRIME_LEVEL = 16,
  parameter bit HOLD_LAST = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  input  logic clr,
  upsampler_feed_fifo_if.slave s,
  input  logic sample_req,
  output logic [DW-1:0] filter_in,
  output logic [$clog2(DEPTH):0] level,
  output logic running,
  output logic [15:0] underflow_cnt,
  output logic underflow_sticky
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;
  state_t state, state_nxt;
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] last;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic push, pop, req, under, empty;
  assign s.tready = level != (AW+1)'(DEPTH);
  assign empty = level == '0;
  assign push = s.tvalid & s.tready & ~clr;
  assign req = (state == RUN) & enable & sample_req & ~clr;
  assign pop = req & ~empty;
  assign under = req & empty;
  // state register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nxt;
  // next state: clr restarts priming, dropping enable always parks in IDLE
  always_comb begin
    state_nxt = clr ? (enable ? PRIME : IDLE) :
                !enable ? IDLE :
                state == IDLE ? PRIME :
                (state == PRIME && level >= (AW+1)'(PRIME_LEVEL)) ? RUN : state;
  end
  // state-decoded outputs
  always_comb begin
    running = state == RUN;
  end
  // sample storage; contents need no reset since level gates every read
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= s.tdata;
  // pointers, level, output register and underflow status
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      last <= '0;
      filter_in <= '0;
      underflow_cnt <= '0;
      underflow_sticky <= 1'b0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      last <= '0;
      filter_in <= '0;
      underflow_cnt <= '0;
      underflow_sticky <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (pop) last <= mem[rd_ptr];
      level <= level + (AW+1)'(push) - (AW+1)'(pop);
      filter_in <= (state != RUN || !enable) ? '0 :
                   pop ? mem[rd_ptr] :
                   under ? (HOLD_LAST ? last : '0) : filter_in;
      if (under) underflow_cnt <= underflow_cnt + 16'(underflow_cnt != 16'hFFFF);
      if (under) underflow_sticky <= 1'b1;
    end
endmodule
